writeback_controller: RTL
=========================

Name: writeback_controller

Overview:
- Final stage of the simple in-order pipeline. Directly downstream of the execute stage, whose valid/ready output handshake feeds this block.
- Latches one completed instruction and, for loads, aligns and sign/zero-extends the raw AXI read word.
- Performs the register-file write and counts retired instructions.
- Hands the next PC to the fetch stage through a valid/ready handshake, which closes the single-issue loop.

Parameters:
- MINSTRET_W, 64, width of the retired-instruction counter.
- RESET_PC_NEXT, 32'h8000_0000, reset value of next_pc_o.

Ports:
- clock  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- valid_pre_i  input  1  execute stage has a completed instruction
- ready_pre_o  output  1  this block can accept an instruction
- valid_post_o  output  1  next PC is valid for fetch
- ready_post_i  input  1  fetch accepts next PC
- is_load_i  input  1  instruction is a load
- load_type_i  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr_lo_i  input  2  load address bits [1:0]
- rdata_i  input  32  raw 32-bit AXI read word from the execute stage
- alu_result_i  input  32  result for non-load instructions
- rd_we_i  input  1  instruction writes rd
- rd_i  input  5  destination register
- next_pc_i  input  32  PC of the next instruction
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  register-file write address
- rf_wdata_o  output  32  register-file write data
- next_pc_o  output  32  next PC to fetch
- commit_o  output  1  one-cycle retire pulse
- load_err_o  output  1  one-cycle pulse: misaligned or reserved load
- minstret_o  output  MINSTRET_W  retired-instruction count

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, all latched fields 0, minstret_o=0, next_pc_o=RESET_PC_NEXT.
  - rf_we_o, commit_o, load_err_o and valid_post_o are 0.
  - Reset asserted mid-operation abandons the held instruction: no register-file write, no commit, no counter increment.
- States: IDLE, COMMIT, WAIT_READY.
- IDLE:
  - ready_pre_o=1 only in IDLE.
  - On valid_pre_i=1 at a posedge, latch all *_i fields and go to COMMIT.
- COMMIT (exactly one cycle, ready_pre_o=0):
  - rf_we_o = rd_we_q && rd_q!=0 && !err.
  - rf_waddr_o = rd_q.
  - commit_o = !err.
  - load_err_o = err.
  - minstret increments at the posedge ending COMMIT when !err; it wraps from all-ones to 0.
  - next_pc_o is loaded from next_pc_q; it stays loaded even when err=1.
  - Next state is WAIT_READY.
- WAIT_READY:
  - valid_post_o=1.
  - On ready_post_i=1, go to IDLE.
  - next_pc_o holds stable while valid_post_o is high.
- Combinational outputs: rf_we_o, commit_o and load_err_o are asserted only during COMMIT. rf_wdata_o is meaningful only when rf_we_o=1.
- Latency: accept at edge N, register-file write and commit during cycle N+1, valid_post_o from cycle N+2. With ready_post_i tied high, throughput is 1 instruction per 3 cycles.
- Write data when is_load_q=0: alu_result_q.
- Write data when is_load_q=1, with b = rdata_q >> (8*addr_lo_q) and h = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0]:
  - LB: sign-extend b[7:0].
  - LBU: zero-extend b[7:0].
  - LH: sign-extend h.
  - LHU: zero-extend h.
  - LW: rdata_q.
- err (loads only):
  - LH/LHU with addr_lo_q[0]=1.
  - LW with addr_lo_q!=0.
  - load_type 011, 110 or 111.
- rd=0: no write is ever issued, but commit_o and minstret still count the instruction.
- valid_pre_i asserted outside IDLE is ignored; upstream holds it until ready_pre_o=1.

Test Plan:
- Reset held 2 cycles, then released -> minstret_o=0, next_pc_o=32'h8000_0000, ready_pre_o=1, all pulses 0.
- ALU op: rd=5, alu_result=32'h1234_5678, next_pc=32'h8000_0004 -> rf_we_o=1, waddr=5, wdata=32'h1234_5678 one cycle after accept; minstret=1; valid_post_o held until ready_post_i; then ready_pre_o=1.
- Loads with rdata=32'h80FF_7F01, rd=3:
  - LB addr_lo=3 -> FFFF_FF80
  - LBU addr_lo=2 -> 0000_00FF
  - LH addr_lo=2 -> FFFF_80FF
  - LHU addr_lo=0 -> 0000_7F01
  - LW addr_lo=0 -> 80FF_7F01
- Misaligned LW addr_lo=2, then LH addr_lo=1, then funct3=011 -> load_err_o pulses each time, rf_we_o=0, commit_o=0, minstret unchanged, valid_post_o still asserted.
- rd=0 with rd_we=1 -> rf_we_o=0 and commit_o=1. ready_post_i held low 5 cycles -> state stays WAIT_READY, valid_pre_i ignored. Reset asserted during WAIT_READY -> IDLE, no extra commit.
- Force minstret to all-ones via a run, or use MINSTRET_W=4 with 16 commits -> wraps to 0.

Source files
------------

// File: rtl/writeback_controller_if.sv
// writeback_controller_if: execute-to-writeback, register-file and fetch-handoff signals of the writeback stage
interface writeback_controller_if #(parameter int MINSTRET_W = 64);
  logic valid_pre_i;
  logic ready_pre_o;
  logic valid_post_o;
  logic ready_post_i;
  logic is_load_i;
  logic [2:0] load_type_i;
  logic [1:0] addr_lo_i;
  logic [31:0] rdata_i;
  logic [31:0] alu_result_i;
  logic rd_we_i;
  logic [4:0] rd_i;
  logic [31:0] next_pc_i;
  logic rf_we_o;
  logic [4:0] rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] next_pc_o;
  logic commit_o;
  logic load_err_o;
  logic [MINSTRET_W-1:0] minstret_o;
  modport master (
    output valid_pre_i, ready_post_i, is_load_i, load_type_i, addr_lo_i, rdata_i,
           alu_result_i, rd_we_i, rd_i, next_pc_i,
    input  ready_pre_o, valid_post_o, rf_we_o, rf_waddr_o, rf_wdata_o, next_pc_o,
           commit_o, load_err_o, minstret_o
  );
  modport slave (
    input  valid_pre_i, ready_post_i, is_load_i, load_type_i, addr_lo_i, rdata_i,
           alu_result_i, rd_we_i, rd_i, next_pc_i,
    output ready_pre_o, valid_post_o, rf_we_o, rf_waddr_o, rf_wdata_o, next_pc_o,
           commit_o, load_err_o, minstret_o
  );
endinterface

// File: rtl/writeback_controller.sv
// writeback_controller: latches one finished instruction, aligns load data, writes the register file, retires and hands off next PC
module writeback_controller #(
  parameter int MINSTRET_W = 64,
  parameter logic [31:0] RESET_PC_NEXT = 32'h8000_0000
) (
  input logic clock,
  input logic reset,
  writeback_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COMMIT, WAIT_READY} state_t;
  state_t state_q, state_d;
  logic is_load_q, rd_we_q, err;
  logic [2:0] load_type_q;
  logic [1:0] addr_lo_q;
  logic [4:0] rd_q;
  logic [31:0] rdata_q, alu_q, next_pc_q, next_pc_r, b, load_data;
  logic [15:0] h;
  logic [MINSTRET_W-1:0] minstret_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      is_load_q <= 1'b0;
      load_type_q <= '0;
      addr_lo_q <= '0;
      rdata_q <= '0;
      alu_q <= '0;
      rd_we_q <= 1'b0;
      rd_q <= '0;
      next_pc_q <= '0;
      next_pc_r <= RESET_PC_NEXT;
      minstret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.valid_pre_i) begin
        is_load_q <= bus.is_load_i;
        load_type_q <= bus.load_type_i;
        addr_lo_q <= bus.addr_lo_i;
        rdata_q <= bus.rdata_i;
        alu_q <= bus.alu_result_i;
        rd_we_q <= bus.rd_we_i;
        rd_q <= bus.rd_i;
        next_pc_q <= bus.next_pc_i;
      end
      // Next PC is handed on even for a faulting load so fetch can proceed
      if (state_q == COMMIT) begin
        next_pc_r <= next_pc_q;
        if (!err) minstret_q <= minstret_q + MINSTRET_W'(1);
      end
    end
  end
  // funct3[1] selects word, funct3[0] halfword, funct3[2] suppresses sign extension
  always_comb begin
    b = rdata_q >> {addr_lo_q, 3'b000};
    h = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = load_type_q[1] ? rdata_q :
                load_type_q[0] ? {{16{h[15] & ~load_type_q[2]}}, h} :
                                 {{24{b[7] & ~load_type_q[2]}}, b[7:0]};
    err = is_load_q && (load_type_q == 3'b011 || load_type_q[2:1] == 2'b11 ||
                        (load_type_q[1:0] == 2'b01 && addr_lo_q[0]) ||
                        (load_type_q == 3'b010 && addr_lo_q != 2'b00));
  end
  always_comb begin
    state_d = state_q;
    bus.ready_pre_o = 1'b0;
    bus.valid_post_o = 1'b0;
    bus.rf_we_o = 1'b0;
    bus.commit_o = 1'b0;
    bus.load_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ready_pre_o = 1'b1;
        state_d = bus.valid_pre_i ? COMMIT : IDLE;
      end
      COMMIT: begin
        bus.rf_we_o = rd_we_q && rd_q != 5'd0 && !err;
        bus.commit_o = !err;
        bus.load_err_o = err;
        state_d = WAIT_READY;
      end
      default: begin
        bus.valid_post_o = 1'b1;
        state_d = bus.ready_post_i ? IDLE : WAIT_READY;
      end
    endcase
  end
  assign bus.rf_waddr_o = rd_q;
  assign bus.rf_wdata_o = is_load_q ? load_data : alu_q;
  assign bus.next_pc_o = next_pc_r;
  assign bus.minstret_o = minstret_q;
endmodule
